data_mem_ctrl: RTL

Parametrised data memory for the MIPS32 datapath with a valid/ready request port and configurable access latency. It supports byte, halfword and word loads and stores, with little-endian lane placement and sign/zero extension on loads. Misaligned or out-of-range accesses are reported with an error flag and have no effect on memory. It sits behind the load/store unit of the multi-cycle and pipelined cores and replaces the fixed word-only combinational-read memory.

---
 rtl/data_mem_ctrl_if.sv | 39 +++
 rtl/data_mem_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if
//   Request/response bundle between a load/store unit and data_mem_ctrl.
//   master : drives the request fields and receives the response.
//   slave  : the memory controller side.
//   Signals:
//     req_valid/req_ready : request handshake
//     req_we              : 1 = store, 0 = load
//     req_size            : 00 byte, 01 half, 10 word, 11 illegal
//     req_unsigned        : zero-extend loads when 1
//     req_addr            : byte address
//     req_wdata           : right-justified store data
//     rsp_valid           : one-cycle response pulse
//     rsp_rdata           : extended load data (0 for stores/errors)
//     rsp_err             : misaligned, out of range or illegal size
interface data_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-addressable data memory with a valid/ready request port and a
//   configurable access latency (1..8). Supports byte/half/word loads and
//   stores with little-endian lane placement and sign/zero extension.
//   Misaligned, out-of-range or illegal-size accesses flag rsp_err and
//   leave memory untouched.
//   Ports:
//     clk   : clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : data_mem_ctrl_if slave modport (request + response)
//   Only DATA_WIDTH = 32 is supported; lane logic assumes four bytes.
module data_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int LATENCY    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus
);

  localparam int IDX_W = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_WORDS = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [2:0] CNT_LOAD = (LATENCY >= 2) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic accept;
  logic commit;

  // Request fields captured at accept, used when the commit happens later.
  logic                  req_we_q;
  logic [1:0]            req_size_q;
  logic                  req_uns_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;

  // Operation seen at the commit edge.
  logic                  op_we;
  logic [1:0]            op_size;
  logic                  op_uns;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_WIDTH-1:0] op_wdata;
  logic                  op_err;
  logic [IDX_W-1:0]      op_idx;
  logic [3:0]            op_be;
  logic [DATA_WIDTH-1:0] op_lane_wdata;

  // Response side.
  logic [DATA_WIDTH-1:0] raw_q;
  logic                  rsp_err_q;
  logic                  rsp_ld_q;
  logic [1:0]            rsp_size_q;
  logic [1:0]            rsp_off_q;
  logic                  rsp_uns_q;
  logic [7:0]            raw_byte [4];
  logic [DATA_WIDTH-1:0] rdata_c;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  assign bus.req_ready = (state_q != WAIT);
  assign bus.rsp_valid = (state_q == RESP);
  assign accept        = bus.req_valid && (state_q != WAIT);

  // With LATENCY=1 the commit coincides with the accept edge; otherwise it
  // is the edge leaving WAIT with the counter exhausted.
  assign commit = (LATENCY == 1) ? accept : ((state_q == WAIT) && (cnt_q == 3'd0));

  // WAIT is only ever entered when LATENCY>1, so the latched fields are the
  // right source there and the live bus fields are right everywhere else.
  always_comb begin
    op_we    = bus.req_we;
    op_size  = bus.req_size;
    op_uns   = bus.req_unsigned;
    op_addr  = bus.req_addr;
    op_wdata = bus.req_wdata;
    if (state_q == WAIT) begin
      op_we    = req_we_q;
      op_size  = req_size_q;
      op_uns   = req_uns_q;
      op_addr  = req_addr_q;
      op_wdata = req_wdata_q;
    end
  end

  assign op_idx = op_addr[IDX_W+1:2];

  always_comb begin
    op_err = 1'b0;
    if (op_size == 2'b11)                              op_err = 1'b1;
    if ((op_size == 2'b01) && op_addr[0])              op_err = 1'b1;
    if ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) op_err = 1'b1;
    if ({2'b00, op_addr[ADDR_WIDTH-1:2]} >= MEM_WORDS) op_err = 1'b1;
  end

  // Replicate the right-justified data onto every lane; the byte enables
  // decide which lanes actually land.
  always_comb begin
    op_be         = 4'b0000;
    op_lane_wdata = op_wdata;
    case (op_size)
      2'b00: begin
        op_be         = 4'b0001 << op_addr[1:0];
        op_lane_wdata = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        op_be         = op_addr[1] ? 4'b1100 : 4'b0011;
        op_lane_wdata = {2{op_wdata[15:0]}};
      end
      2'b10:   op_be = 4'b1111;
      default: op_be = 4'b0000;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q    <= 1'b0;
      req_size_q  <= 2'b00;
      req_uns_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
    end else if (accept) begin
      req_we_q    <= bus.req_we;
      req_size_q  <= bus.req_size;
      req_uns_q   <= bus.req_unsigned;
      req_addr_q  <= bus.req_addr;
      req_wdata_q <= bus.req_wdata;
    end
  end

  // Memory array: byte-enabled write and registered read share the commit
  // edge, so a load sees the word as it was before this same access.
  // Reset drops state_q to IDLE immediately, which kills a pending commit.
  always_ff @(posedge clk) begin
    if (commit && !op_err) begin
      if (op_we) begin
        for (int i = 0; i < 4; i++) begin
          if (op_be[i]) mem[op_idx][i*8 +: 8] <= op_lane_wdata[i*8 +: 8];
        end
      end
      raw_q <= mem[op_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_err_q  <= 1'b0;
      rsp_ld_q   <= 1'b0;
      rsp_size_q <= 2'b00;
      rsp_off_q  <= 2'b00;
      rsp_uns_q  <= 1'b0;
    end else if (commit) begin
      rsp_err_q  <= op_err;
      rsp_ld_q   <= !op_we && !op_err;
      rsp_size_q <= op_size;
      rsp_off_q  <= op_addr[1:0];
      rsp_uns_q  <= op_uns;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign raw_byte[gi] = raw_q[gi*8 +: 8];
  end

  // Extraction and extension; rsp_ld_q forces zero for stores and errors.
  always_comb begin
    rdata_c = '0;
    if (rsp_ld_q) begin
      case (rsp_size_q)
        2'b00: rdata_c = {{24{!rsp_uns_q && raw_byte[rsp_off_q][7]}}, raw_byte[rsp_off_q]};
        2'b01: begin
          if (rsp_off_q[1]) rdata_c = {{16{!rsp_uns_q && raw_q[31]}}, raw_q[31:16]};
          else              rdata_c = {{16{!rsp_uns_q && raw_q[15]}}, raw_q[15:0]};
        end
        default: rdata_c = raw_q;
      endcase
    end
  end

  assign bus.rsp_rdata = rdata_c;
  assign bus.rsp_err   = rsp_err_q;

endmodule
